can_form_checker: RTL and testbench
===================================

Name: can_form_checker

Overview:
- Parametrised CAN form-error checker for every fixed-form field: CRC delimiter, ACK delimiter, EOF, error delimiter and overload delimiter.
- The frame sequencer supplies the current field code. This block counts bit positions inside multi-bit fields and evaluates RX at each sample-point strobe.
- It flags form errors, requests overload frames where a dominant bit is legal, and captures the first error for the error-management unit.

Parameters:
- EOF_LEN, 7, number of EOF bits checked.
- DELIM_LEN, 8, length of the error and overload delimiters.
- LAST_BIT_TOLERANT, 1, if 1: a dominant last EOF bit (receiver only) or a dominant last delimiter bit raises overload_req instead of a form error.
- CNT_W, 4, bit-index width; must satisfy 2^CNT_W > max(EOF_LEN, DELIM_LEN).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- sp  in  1  sample-point strobe, one clk wide per CAN bit.
- rx  in  1  sampled bus level (0 = dominant).
- field  in  3  current field: 0 NONE, 1 CRC_DELIM, 2 ACK_DELIM, 3 EOF, 4 ERR_DELIM, 5 OVL_DELIM, 6-7 reserved (treated as NONE).
- is_tx  in  1  node is transmitter of the current frame.
- clr  in  1  clears the sticky error and its capture registers.
- form_err_n  out  1  active-low form error for the last sampled bit, held until the next sp.
- form_err_pulse  out  1  one-clk high pulse per detected error.
- overload_req  out  1  one-clk pulse; tolerated dominant last bit seen.
- form_err_sticky  out  1  set on the first error, held until clr.
- err_field  out  3  field code of the first captured error.
- err_idx  out  CNT_W  bit index of the first captured error.

Behaviour:
- Reset (clk edge with reset=1):
  - form_err_n=1, form_err_pulse=0, overload_req=0, form_err_sticky=0, err_field=0, err_idx=0.
  - Internal prev_field=NONE, idx=0.
  - Reset overrides sp and clr in the same cycle.
- Evaluation happens only on clk edges with sp=1. All outputs are registered, so results appear one clk after the sp cycle.
- Between sp cycles:
  - form_err_n holds its value.
  - form_err_pulse and overload_req are 0.
  - idx and prev_field hold.
- Bit index on sp:
  - field==NONE or reserved: idx<=0, no check.
  - field!=prev_field: current bit index is 0.
  - Otherwise: current index = idx+1, saturating at 2^CNT_W-1.
  - prev_field<=field.
- Check on sp; error = rx==0 under these rules:
  - CRC_DELIM, index 0: error.
  - ACK_DELIM, index 0: error.
  - EOF, index 0..EOF_LEN-1: error, with one exception. If LAST_BIT_TOLERANT=1, index==EOF_LEN-1 and is_tx=0, then no error and overload_req pulses.
  - ERR_DELIM or OVL_DELIM, index 0..DELIM_LEN-1: error, with one exception. If LAST_BIT_TOLERANT=1 and index==DELIM_LEN-1, then no error and overload_req pulses.
  - Any index beyond the field length: no check, no error (the sequencer owns field length).
  - rx==1: never an error.
- On sp, form_err_n <= ~error; form_err_pulse <= error.
- Sticky and capture:
  - On error with form_err_sticky=0: sticky<=1, err_field<=field, err_idx<=current index.
  - Later errors do not overwrite the capture.
- clr:
  - Clears sticky, err_field and err_idx.
  - If clr coincides with an sp error, set wins and that error is captured.
  - clr does not affect form_err_n or the bit counter.
- Field change without sp has no effect until the next sp.
- Reset mid-field: the next sp in a non-NONE field is treated as index 0.

Test Plan:
- Recessive frame tail: field CRC_DELIM (1 sp), ACK_DELIM (1 sp), EOF (7 sp), all rx=1 -> form_err_n stays 1, no pulses, sticky=0.
- ACK delimiter dominant: field=2, rx=0 at sp -> one clk later form_err_n=0, form_err_pulse=1, err_field=2, err_idx=0, sticky=1. Next sp with field=3, rx=1 -> form_err_n=1.
- EOF bit 3 dominant, is_tx=0 -> err_field=3, err_idx=3. Then EOF bit 6 dominant -> capture unchanged, second pulse asserted.
- EOF last bit dominant:
  - is_tx=0 -> overload_req pulse, form_err_n=1, sticky=0.
  - is_tx=1 -> form error, err_idx=6.
  - LAST_BIT_TOLERANT=0, is_tx=0 -> form error.
- ERR_DELIM index 7 dominant -> overload_req only; index 2 dominant -> error, err_idx=2. A 10th sp in the same field with rx=0 -> no error (beyond length).
- clr asserted in the same clk as an sp error on CRC_DELIM -> sticky=1, err_field=1. reset asserted mid-EOF after 4 bits, then EOF sp -> index 0 and all outputs at reset values before it.

Source files
------------

// File: rtl/can_form_checker.sv
// can_form_checker: CAN form-error checker for the fixed-form fields (CRC/ACK delimiters, EOF, error/overload delimiters)
//   clk             in   system clock
//   reset           in   synchronous active-high reset
//   sp              in   sample-point strobe, one clk per CAN bit
//   rx              in   sampled bus level (0 = dominant)
//   field           in   current field code (0 NONE,1 CRC_DELIM,2 ACK_DELIM,3 EOF,4 ERR_DELIM,5 OVL_DELIM,6-7 NONE)
//   is_tx           in   node is transmitter of the current frame
//   clr             in   clears sticky error and capture registers
//   form_err_n      out  active-low form error of last sampled bit, held until next sp
//   form_err_pulse  out  one-clk pulse per detected error
//   overload_req    out  one-clk pulse when a tolerated dominant last bit is seen
//   form_err_sticky out  set on first error, held until clr
//   err_field       out  field code of first captured error
//   err_idx         out  bit index of first captured error
module can_form_checker #(
    parameter int EOF_LEN           = 7,
    parameter int DELIM_LEN         = 8,
    parameter bit LAST_BIT_TOLERANT = 1,
    parameter int CNT_W             = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sp,
    input  logic             rx,
    input  logic [2:0]       field,
    input  logic             is_tx,
    input  logic             clr,
    output logic             form_err_n,
    output logic             form_err_pulse,
    output logic             overload_req,
    output logic             form_err_sticky,
    output logic [2:0]       err_field,
    output logic [CNT_W-1:0] err_idx
);
    localparam logic [2:0] F_NONE = 3'd0;
    localparam logic [2:0] F_CRC  = 3'd1;
    localparam logic [2:0] F_ACK  = 3'd2;
    localparam logic [2:0] F_EOF  = 3'd3;
    localparam logic [2:0] F_ERR  = 3'd4;
    localparam logic [2:0] F_OVL  = 3'd5;
    localparam logic [CNT_W-1:0] IDX_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] EOF_LAST  = CNT_W'(EOF_LEN - 1);
    localparam logic [CNT_W-1:0] DELIM_LST = CNT_W'(DELIM_LEN - 1);

    logic [2:0]       prev_field;
    logic [CNT_W-1:0] idx;
    logic [2:0]       fld;
    logic [CNT_W-1:0] cur_idx;
    logic             in_range;
    logic             tolerant;
    logic             dominant;
    logic             error;
    logic             ovl;

    // Reserved codes behave exactly like NONE, including for prev_field tracking.
    assign fld = (field > F_OVL) ? F_NONE : field;

    always_comb begin
        cur_idx  = (fld != prev_field) ? '0 : (idx == IDX_MAX ? IDX_MAX : idx + 1'b1);
        in_range = ((fld == F_CRC || fld == F_ACK) && cur_idx == '0) ||
                   (fld == F_EOF && cur_idx <= EOF_LAST) ||
                   ((fld == F_ERR || fld == F_OVL) && cur_idx <= DELIM_LST);
        // Receivers may see a dominant last EOF bit; any node may see a dominant last delimiter bit.
        tolerant = LAST_BIT_TOLERANT &&
                   ((fld == F_EOF && cur_idx == EOF_LAST && !is_tx) ||
                    ((fld == F_ERR || fld == F_OVL) && cur_idx == DELIM_LST));
        dominant = !rx && in_range;
        error    = dominant && !tolerant;
        ovl      = dominant && tolerant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            form_err_n      <= 1'b1;
            form_err_pulse  <= 1'b0;
            overload_req    <= 1'b0;
            form_err_sticky <= 1'b0;
            err_field       <= F_NONE;
            err_idx         <= '0;
            prev_field      <= F_NONE;
            idx             <= '0;
        end else begin
            form_err_pulse <= 1'b0;
            overload_req   <= 1'b0;
            if (clr) begin
                form_err_sticky <= 1'b0;
                err_field       <= F_NONE;
                err_idx         <= '0;
            end
            if (sp) begin
                idx            <= (fld == F_NONE) ? '0 : cur_idx;
                prev_field     <= fld;
                form_err_n     <= !error;
                form_err_pulse <= error;
                overload_req   <= ovl;
                // A coinciding clr releases the capture so this error is taken.
                if (error && (!form_err_sticky || clr)) begin
                    form_err_sticky <= 1'b1;
                    err_field       <= fld;
                    err_idx         <= cur_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_can_form_checker.sv
// tb_can_form_checker: directed self-checking bench for can_form_checker (tolerant and non-tolerant instances)
module tb_can_form_checker;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sp = 1'b0;
    logic       rx = 1'b1;
    logic [2:0] field = 3'd0;
    logic       is_tx = 1'b0;
    logic       clr = 1'b0;

    logic       n1, p1, o1, s1;
    logic [2:0] f1;
    logic [3:0] i1;
    logic       n2, p2, o2, s2;
    logic [2:0] f2;
    logic [3:0] i2;

    int compared = 0;
    int mismatched = 0;

    // {form_err_n, form_err_pulse, overload_req, sticky, err_field, err_idx}
    logic [10:0] st1, st2;
    assign st1 = {n1, p1, o1, s1, f1, i1};
    assign st2 = {n2, p2, o2, s2, f2, i2};

    always #5 clk = ~clk;

    can_form_checker #(.EOF_LEN(7), .DELIM_LEN(8), .LAST_BIT_TOLERANT(1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .sp(sp), .rx(rx), .field(field), .is_tx(is_tx), .clr(clr),
        .form_err_n(n1), .form_err_pulse(p1), .overload_req(o1), .form_err_sticky(s1),
        .err_field(f1), .err_idx(i1)
    );

    can_form_checker #(.EOF_LEN(7), .DELIM_LEN(8), .LAST_BIT_TOLERANT(0), .CNT_W(4)) dut_nt (
        .clk(clk), .reset(reset), .sp(sp), .rx(rx), .field(field), .is_tx(is_tx), .clr(clr),
        .form_err_n(n2), .form_err_pulse(p2), .overload_req(o2), .form_err_sticky(s2),
        .err_field(f2), .err_idx(i2)
    );

    // One sp cycle; returns at the following negedge where the registered result is visible.
    task automatic bit_sp(input logic [2:0] f, input logic r, input logic t, input logic c);
        @(negedge clk);
        field = f; rx = r; is_tx = t; clr = c; sp = 1'b1;
        @(negedge clk);
        sp = 1'b0; clr = 1'b0; rx = 1'b1;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compared++;
        if (st1 !== 11'b1000_000_0000) begin
            mismatched++;
            $display("FAIL reset_tol: got %b want %b", st1, 11'b1000_000_0000);
        end
        compared++;
        if (st2 !== 11'b1000_000_0000) begin
            mismatched++;
            $display("FAIL reset_nt: got %b want %b", st2, 11'b1000_000_0000);
        end
    endtask

    task automatic test_recessive();
        bit_sp(3'd6, 1'b0, 1'b0, 1'b0);
        compared++;
        if (st1 !== 11'b1000_000_0000) begin
            mismatched++;
            $display("FAIL reserved_field: got %b want %b", st1, 11'b1000_000_0000);
        end
        bit_sp(3'd1, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd2, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            bit_sp(3'd3, 1'b1, 1'b0, 1'b0);
            compared++;
            if (st1 !== 11'b1000_000_0000) begin
                mismatched++;
                $display("FAIL recessive_eof%0d: got %b want %b", k, st1, 11'b1000_000_0000);
            end
        end
    endtask

    task automatic test_ack_dom();
        bit_sp(3'd0, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd2, 1'b0, 1'b0, 1'b0);
        compared++;
        if (st1 !== 11'b0101_010_0000) begin
            mismatched++;
            $display("FAIL ack_dom: got %b want %b", st1, 11'b0101_010_0000);
        end
        @(negedge clk);
        compared++;
        if (st1 !== 11'b0001_010_0000) begin
            mismatched++;
            $display("FAIL ack_hold: got %b want %b", st1, 11'b0001_010_0000);
        end
        bit_sp(3'd3, 1'b1, 1'b0, 1'b0);
        compared++;
        if (st1 !== 11'b1001_010_0000) begin
            mismatched++;
            $display("FAIL ack_next_rec: got %b want %b", st1, 11'b1001_010_0000);
        end
        do_clr();
        compared++;
        if (st1 !== 11'b1000_000_0000) begin
            mismatched++;
            $display("FAIL clr_only: got %b want %b", st1, 11'b1000_000_0000);
        end
    endtask

    task automatic test_eof_errors();
        bit_sp(3'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) bit_sp(3'd3, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd3, 1'b0, 1'b0, 1'b0);
        compared++;
        if (st1 !== 11'b0101_011_0011) begin
            mismatched++;
            $display("FAIL eof_bit3: got %b want %b", st1, 11'b0101_011_0011);
        end
        bit_sp(3'd3, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd3, 1'b1, 1'b0, 1'b0);
        compared++;
        if (st1 !== 11'b1001_011_0011) begin
            mismatched++;
            $display("FAIL eof_bit5: got %b want %b", st1, 11'b1001_011_0011);
        end
        bit_sp(3'd3, 1'b0, 1'b1, 1'b0);
        compared++;
        if (st1 !== 11'b0101_011_0011) begin
            mismatched++;
            $display("FAIL eof_bit6_second: got %b want %b", st1, 11'b0101_011_0011);
        end
        do_clr();
    endtask

    task automatic test_eof_last();
        bit_sp(3'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) bit_sp(3'd3, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd3, 1'b0, 1'b0, 1'b0);
        compared++;
        if (st1 !== 11'b1010_000_0000) begin
            mismatched++;
            $display("FAIL eof_last_rx_tol: got %b want %b", st1, 11'b1010_000_0000);
        end
        compared++;
        if (st2 !== 11'b0101_011_0110) begin
            mismatched++;
            $display("FAIL eof_last_rx_nt: got %b want %b", st2, 11'b0101_011_0110);
        end
        do_clr();
        bit_sp(3'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) bit_sp(3'd3, 1'b1, 1'b1, 1'b0);
        bit_sp(3'd3, 1'b0, 1'b1, 1'b0);
        compared++;
        if (st1 !== 11'b0101_011_0110) begin
            mismatched++;
            $display("FAIL eof_last_tx: got %b want %b", st1, 11'b0101_011_0110);
        end
        do_clr();
    endtask

    task automatic test_delims();
        bit_sp(3'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) bit_sp(3'd4, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd4, 1'b0, 1'b0, 1'b0);
        compared++;
        if (st1 !== 11'b1010_000_0000) begin
            mismatched++;
            $display("FAIL err_delim_last: got %b want %b", st1, 11'b1010_000_0000);
        end
        bit_sp(3'd0, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd4, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd4, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd4, 1'b0, 1'b0, 1'b0);
        compared++;
        if (st1 !== 11'b0101_100_0010) begin
            mismatched++;
            $display("FAIL err_delim_bit2: got %b want %b", st1, 11'b0101_100_0010);
        end
        for (int k = 3; k < 9; k++) bit_sp(3'd4, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd4, 1'b0, 1'b0, 1'b0);
        compared++;
        if (st1 !== 11'b1001_100_0010) begin
            mismatched++;
            $display("FAIL err_delim_beyond: got %b want %b", st1, 11'b1001_100_0010);
        end
        // Run the index into saturation and past it; still beyond length.
        for (int k = 10; k < 18; k++) bit_sp(3'd4, 1'b0, 1'b0, 1'b0);
        compared++;
        if (st1 !== 11'b1001_100_0010) begin
            mismatched++;
            $display("FAIL err_delim_sat: got %b want %b", st1, 11'b1001_100_0010);
        end
        do_clr();
        bit_sp(3'd5, 1'b0, 1'b0, 1'b0);
        compared++;
        if (st1 !== 11'b0101_101_0000) begin
            mismatched++;
            $display("FAIL ovl_delim_bit0: got %b want %b", st1, 11'b0101_101_0000);
        end
    endtask

    task automatic test_clr_coincide();
        bit_sp(3'd1, 1'b0, 1'b0, 1'b1);
        compared++;
        if (st1 !== 11'b0101_001_0000) begin
            mismatched++;
            $display("FAIL clr_with_err: got %b want %b", st1, 11'b0101_001_0000);
        end
    endtask

    task automatic test_reset_mid();
        do_clr();
        bit_sp(3'd0, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd3, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd3, 1'b1, 1'b0, 1'b0);
        bit_sp(3'd3, 1'b0, 1'b0, 1'b0);
        bit_sp(3'd3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compared++;
        if (st1 !== 11'b1000_000_0000) begin
            mismatched++;
            $display("FAIL reset_mid: got %b want %b", st1, 11'b1000_000_0000);
        end
        bit_sp(3'd3, 1'b0, 1'b1, 1'b0);
        compared++;
        if (st1 !== 11'b0101_011_0000) begin
            mismatched++;
            $display("FAIL after_reset_idx0: got %b want %b", st1, 11'b0101_011_0000);
        end
    endtask

    initial begin
        test_reset();
        test_recessive();
        test_ack_dom();
        test_eof_errors();
        test_eof_last();
        test_delims();
        test_clr_coincide();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
